// File: rtl/pc_pkg.sv
// Shared definitions for the fetch-stage program-counter generator:
// branch funct3 encodings, default reset/trap vectors and the branch
// condition decode used by pc_gen.
package pc_pkg;

  localparam logic [2:0] BR_BEQ  = 3'b000;
  localparam logic [2:0] BR_BNE  = 3'b001;
  localparam logic [2:0] BR_BLT  = 3'b100;
  localparam logic [2:0] BR_BGE  = 3'b101;
  localparam logic [2:0] BR_BLTU = 3'b110;
  localparam logic [2:0] BR_BGEU = 3'b111;

  localparam int unsigned DEFAULT_RESET_PC = 0;
  localparam int unsigned DEFAULT_TRAP_PC  = 4;

  // Maps a branch funct3 and the ALU compare flags to "branch condition met".
  // The two reserved encodings (010, 011) never take.
  function automatic logic branch_cond(input logic [2:0] op,
                                       input logic       zero,
                                       input logic       lt,
                                       input logic       ltu);
    logic c;
    c = 1'b0;
    case (op)
      BR_BEQ:  c = zero;
      BR_BNE:  c = !zero;
      BR_BLT:  c = lt;
      BR_BGE:  c = !lt;
      BR_BLTU: c = ltu;
      BR_BGEU: c = !ltu;
      default: c = 1'b0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/pc_rca.sv
// Ripple-carry adder used for pc+4 and the two redirect targets, built
// as a chain of single-bit full-adder cells. All sums wrap modulo 2^W,
// so the final carry is never formed.

module pc_fa (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

module pc_rca #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] sum
);

  logic [W-1:0] carry;

  assign carry[0] = 1'b0;

  // Full-adder cells for every bit that feeds a carry into the next one.
  for (genvar i = 0; i < W - 1; i++) begin : g_bit
    pc_fa u_fa (
      .a    (a[i]),
      .b    (b[i]),
      .cin  (carry[i]),
      .s    (sum[i]),
      .cout (carry[i+1])
    );
  end

  // The top bit only needs its sum; the carry out of it is discarded
  // because addresses wrap silently.
  assign sum[W-1] = a[W-1] ^ b[W-1] ^ carry[W-1];

endmodule

// File: rtl/pc_gen.sv
// Fetch-stage program-counter generator. Holds the fetch PC, steps it by 4,
// resolves branch / JAL / JALR redirects from EX and buffers a redirect
// that arrives while fetch cannot advance, so it is applied later.
module pc_gen
  import pc_pkg::*;
#(
  parameter int                ADDR_W   = 8,
  parameter int                IMM_W    = 64,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEFAULT_RESET_PC),
  parameter logic [ADDR_W-1:0] TRAP_PC  = ADDR_W'(DEFAULT_TRAP_PC)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_ready,
  input  logic              stall,
  input  logic              ex_valid,
  input  logic [2:0]        ex_op,
  input  logic              ex_branch,
  input  logic              ex_jal,
  input  logic              ex_jalr,
  input  logic [ADDR_W-1:0] ex_pc,
  input  logic [ADDR_W-1:0] ex_rs1,
  input  logic [IMM_W-1:0]  ex_imm,
  input  logic              flag_zero,
  input  logic              flag_lt,
  input  logic              flag_ltu,
  output logic [ADDR_W-1:0] pc,
  output logic              pc_valid,
  output logic [ADDR_W-1:0] pc_plus4,
  output logic              flush,
  output logic              misalign_err
);

  logic [ADDR_W-1:0] br_offset;
  logic [ADDR_W-1:0] br_sum;
  logic [ADDR_W-1:0] jalr_sum;
  logic [ADDR_W-1:0] target;
  logic [ADDR_W-1:0] redirect;
  logic              take;
  logic              advance;
  logic              misaligned;
  logic              pend_v;
  logic [ADDR_W-1:0] pend_addr;
  logic              unused_bits;

  // Branch/JAL offsets are halfword-scaled; the immediate's upper bits and
  // the JALR sum's LSB (always forced to zero) carry no information here.
  assign br_offset   = {ex_imm[ADDR_W-2:0], 1'b0};
  assign unused_bits = ^{ex_imm[IMM_W-1:ADDR_W], jalr_sum[0]};

  pc_rca #(.W(ADDR_W)) u_add_seq (
    .a   (pc),
    .b   (ADDR_W'(4)),
    .sum (pc_plus4)
  );

  pc_rca #(.W(ADDR_W)) u_add_br (
    .a   (ex_pc),
    .b   (br_offset),
    .sum (br_sum)
  );

  pc_rca #(.W(ADDR_W)) u_add_jalr (
    .a   (ex_rs1),
    .b   (ex_imm[ADDR_W-1:0]),
    .sum (jalr_sum)
  );

  // Decide whether EX redirects fetch and where to; a misaligned target is
  // replaced by the trap vector so fetch never issues an illegal address.
  always_comb begin
    take = ex_valid & (ex_jal | ex_jalr |
                       (ex_branch & branch_cond(ex_op, flag_zero, flag_lt, flag_ltu)));
    target     = ex_jalr ? {jalr_sum[ADDR_W-1:1], 1'b0} : br_sum;
    misaligned = target[1:0] != 2'b00;
    redirect   = misaligned ? TRAP_PC : target;
    advance    = if_ready & !stall;
  end

  assign flush = take;

  // PC register, pending-redirect buffer and status flags. A redirect taken
  // while fetch is blocked is parked in the buffer; a younger one replaces it,
  // and a redirect that is applied directly makes any parked one stale.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc           <= RESET_PC;
      pc_valid     <= 1'b0;
      misalign_err <= 1'b0;
      pend_v       <= 1'b0;
      pend_addr    <= RESET_PC;
    end else begin
      pc_valid     <= 1'b1;
      misalign_err <= take & misaligned;
      if (advance && take) begin
        pc     <= redirect;
        pend_v <= 1'b0;
      end else if (advance && pend_v) begin
        pc     <= pend_addr;
        pend_v <= 1'b0;
      end else if (advance) begin
        pc <= pc_plus4;
      end
      if (take && !advance) begin
        pend_addr <= redirect;
        pend_v    <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen (ADDR_W = 8, RESET_PC = 0, TRAP_PC = 4).
// A table of per-cycle vectors drives the block; the combinational flush is
// compared in the same cycle and the post-edge expectations travel through a
// scoreboard queue to be compared after the clock.
module tb_pc_gen;
  import pc_pkg::*;

  typedef enum logic [1:0] {K_NONE, K_BR, K_JAL, K_JALR} kind_t;

  typedef struct {
    logic        rst_n;
    logic        rdy;
    logic        stl;
    kind_t       kind;
    logic [2:0]  op;
    logic [7:0]  epc;
    logic [7:0]  rs1;
    logic [63:0] imm;
    logic [2:0]  flg;     // {zero, lt, ltu}
    logic        e_flush;
    logic [7:0]  e_pc;
    logic        e_valid;
    logic        e_mis;
  } vec_t;

  typedef struct {
    int         idx;
    logic [7:0] pc;
    logic       valid;
    logic       mis;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        if_ready;
  logic        stall;
  logic        ex_valid;
  logic [2:0]  ex_op;
  logic        ex_branch;
  logic        ex_jal;
  logic        ex_jalr;
  logic [7:0]  ex_pc;
  logic [7:0]  ex_rs1;
  logic [63:0] ex_imm;
  logic        flag_zero;
  logic        flag_lt;
  logic        flag_ltu;
  logic [7:0]  pc;
  logic        pc_valid;
  logic [7:0]  pc_plus4;
  logic        flush;
  logic        misalign_err;

  int   errors = 0;
  int   checks = 0;
  exp_t sb[$];
  vec_t vecs[$];

  pc_gen #(
    .ADDR_W   (8),
    .IMM_W    (64),
    .RESET_PC (8'h00),
    .TRAP_PC  (8'h04)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .if_ready     (if_ready),
    .stall        (stall),
    .ex_valid     (ex_valid),
    .ex_op        (ex_op),
    .ex_branch    (ex_branch),
    .ex_jal       (ex_jal),
    .ex_jalr      (ex_jalr),
    .ex_pc        (ex_pc),
    .ex_rs1       (ex_rs1),
    .ex_imm       (ex_imm),
    .flag_zero    (flag_zero),
    .flag_lt      (flag_lt),
    .flag_ltu     (flag_ltu),
    .pc           (pc),
    .pc_valid     (pc_valid),
    .pc_plus4     (pc_plus4),
    .flush        (flush),
    .misalign_err (misalign_err)
  );

  // Free-running 10-time-unit clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic vec_t mk(logic r, logic rdy, logic stl, kind_t k, logic [2:0] op,
                              logic [7:0] epc, logic [7:0] rs1, logic [63:0] imm,
                              logic [2:0] flg, logic ef, logic [7:0] ep, logic ev, logic em);
    vec_t v;
    v.rst_n = r;   v.rdy = rdy;  v.stl = stl;  v.kind = k;   v.op = op;
    v.epc = epc;   v.rs1 = rs1;  v.imm = imm;  v.flg = flg;
    v.e_flush = ef; v.e_pc = ep; v.e_valid = ev; v.e_mis = em;
    return v;
  endfunction

  task automatic checkOutput(input string name, input int idx,
                             input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL vec%0d %s: got %0h, expected %0h", idx, name, actual, expected);
    end
  endtask

  // Drive one vector at the falling edge, check flush combinationally, queue
  // the post-edge expectation and compare it after the rising edge.
  task automatic applyStimulus(input vec_t v, input int idx);
    exp_t e;
    exp_t got;
    @(negedge clk);
    rst_n     = v.rst_n;
    if_ready  = v.rdy;
    stall     = v.stl;
    ex_valid  = (v.kind != K_NONE);
    ex_branch = (v.kind == K_BR);
    ex_jal    = (v.kind == K_JAL);
    ex_jalr   = (v.kind == K_JALR);
    ex_op     = v.op;
    ex_pc     = v.epc;
    ex_rs1    = v.rs1;
    ex_imm    = v.imm;
    {flag_zero, flag_lt, flag_ltu} = v.flg;
    #1;
    checkOutput("flush", idx, 64'(flush), 64'(v.e_flush));
    e.idx = idx; e.pc = v.e_pc; e.valid = v.e_valid; e.mis = v.e_mis;
    sb.push_back(e);
    @(posedge clk);
    #1;
    got = sb.pop_front();
    checkOutput("pc",           got.idx, 64'(pc),           64'(got.pc));
    checkOutput("pc_plus4",     got.idx, 64'(pc_plus4),     64'(8'(got.pc + 8'd4)));
    checkOutput("pc_valid",     got.idx, 64'(pc_valid),     64'(got.valid));
    checkOutput("misalign_err", got.idx, 64'(misalign_err), 64'(got.mis));
  endtask

  initial begin
    rst_n = 1'b0; if_ready = 1'b1; stall = 1'b0; ex_valid = 1'b0;
    ex_op = 3'b000; ex_branch = 1'b0; ex_jal = 1'b0; ex_jalr = 1'b0;
    ex_pc = 8'h00; ex_rs1 = 8'h00; ex_imm = 64'h0;
    flag_zero = 1'b0; flag_lt = 1'b0; flag_ltu = 1'b0;

    // Reset, release, sequential fetch.
    vecs.push_back(mk(0,1,0,K_NONE,3'b000,8'h00,8'h00,64'd0,3'b000, 0,8'h00,0,0));
    vecs.push_back(mk(0,1,0,K_NONE,3'b000,8'h00,8'h00,64'd0,3'b000, 0,8'h00,0,0));
    vecs.push_back(mk(1,1,0,K_NONE,3'b000,8'h00,8'h00,64'd0,3'b000, 0,8'h04,1,0));
    vecs.push_back(mk(1,1,0,K_NONE,3'b000,8'h00,8'h00,64'd0,3'b000, 0,8'h08,1,0));
    // BNE taken, BGE not taken, BEQ backward with wrap, reserved op, BLTU to 0xFC.
    vecs.push_back(mk(1,1,0,K_BR,BR_BNE,8'h10,8'h00,64'd6,3'b000, 1,8'h1C,1,0));
    vecs.push_back(mk(1,1,0,K_BR,BR_BGE,8'h40,8'h00,64'd8,3'b010, 0,8'h20,1,0));
    vecs.push_back(mk(1,1,0,K_BR,BR_BEQ,8'h30,8'h00,64'hFFFF_FFFF_FFFF_FFFE,3'b100, 1,8'h2C,1,0));
    vecs.push_back(mk(1,1,0,K_BR,3'b010,8'h50,8'h00,64'd4,3'b111, 0,8'h30,1,0));
    vecs.push_back(mk(1,1,0,K_BR,BR_BLTU,8'h70,8'h00,64'h46,3'b001, 1,8'hFC,1,0));
    vecs.push_back(mk(1,1,0,K_NONE,3'b000,8'h00,8'h00,64'd0,3'b000, 0,8'h00,1,0));
    // JALR aligned (bit 0 cleared) and misaligned to the trap vector.
    vecs.push_back(mk(1,1,0,K_JALR,3'b000,8'h00,8'h21,64'd4,3'b000, 1,8'h24,1,0));
    vecs.push_back(mk(1,1,0,K_JALR,3'b000,8'h00,8'h22,64'd0,3'b000, 1,8'h04,1,1));
    vecs.push_back(mk(1,1,0,K_NONE,3'b000,8'h00,8'h00,64'd0,3'b000, 0,8'h08,1,0));
    vecs.push_back(mk(1,1,0,K_BR,BR_BLT,8'h08,8'h00,64'd8,3'b000, 0,8'h0C,1,0));
    vecs.push_back(mk(1,1,0,K_BR,BR_BGEU,8'h0C,8'h00,64'd2,3'b000, 1,8'h10,1,0));
    // JAL during a 3-cycle stall.
    vecs.push_back(mk(1,1,1,K_JAL,3'b000,8'h20,8'h00,64'h10,3'b000, 1,8'h10,1,0));
    vecs.push_back(mk(1,1,1,K_NONE,3'b000,8'h00,8'h00,64'd0,3'b000, 0,8'h10,1,0));
    vecs.push_back(mk(1,1,1,K_NONE,3'b000,8'h00,8'h00,64'd0,3'b000, 0,8'h10,1,0));
    vecs.push_back(mk(1,1,0,K_NONE,3'b000,8'h00,8'h00,64'd0,3'b000, 0,8'h40,1,0));
    vecs.push_back(mk(1,1,0,K_NONE,3'b000,8'h00,8'h00,64'd0,3'b000, 0,8'h44,1,0));
    // Two takes during a stall: the younger (0x80) wins.
    vecs.push_back(mk(1,1,1,K_JAL,3'b000,8'h20,8'h00,64'h10,3'b000, 1,8'h44,1,0));
    vecs.push_back(mk(1,1,1,K_JAL,3'b000,8'h40,8'h00,64'h20,3'b000, 1,8'h44,1,0));
    vecs.push_back(mk(1,1,1,K_NONE,3'b000,8'h00,8'h00,64'd0,3'b000, 0,8'h44,1,0));
    vecs.push_back(mk(1,1,0,K_NONE,3'b000,8'h00,8'h00,64'd0,3'b000, 0,8'h80,1,0));
    vecs.push_back(mk(1,1,0,K_NONE,3'b000,8'h00,8'h00,64'd0,3'b000, 0,8'h84,1,0));
    // Reset during the stall drops the pending redirect.
    vecs.push_back(mk(1,1,1,K_JAL,3'b000,8'h20,8'h00,64'h10,3'b000, 1,8'h84,1,0));
    vecs.push_back(mk(0,1,1,K_NONE,3'b000,8'h00,8'h00,64'd0,3'b000, 0,8'h00,0,0));
    vecs.push_back(mk(1,1,1,K_NONE,3'b000,8'h00,8'h00,64'd0,3'b000, 0,8'h00,1,0));
    vecs.push_back(mk(1,1,0,K_NONE,3'b000,8'h00,8'h00,64'd0,3'b000, 0,8'h04,1,0));
    // Memory not ready holds; BLTU not taken; misaligned branch traps.
    vecs.push_back(mk(1,0,0,K_NONE,3'b000,8'h00,8'h00,64'd0,3'b000, 0,8'h04,1,0));
    vecs.push_back(mk(1,1,0,K_BR,BR_BLTU,8'h00,8'h00,64'd0,3'b000, 0,8'h08,1,0));
    vecs.push_back(mk(1,1,0,K_BR,BR_BNE,8'h08,8'h00,64'd1,3'b000, 1,8'h04,1,1));
    vecs.push_back(mk(1,1,0,K_NONE,3'b000,8'h00,8'h00,64'd0,3'b000, 0,8'h08,1,0));

    foreach (vecs[i]) applyStimulus(vecs[i], i);

    // Hand sequence: misaligned JALR while stalled parks the trap vector,
    // which fetch picks up once the stall clears.
    applyStimulus(mk(1,1,1,K_JALR,3'b000,8'h00,8'h33,64'd0,3'b000, 1,8'h08,1,1), 100);
    applyStimulus(mk(1,1,0,K_NONE,3'b000,8'h00,8'h00,64'd0,3'b000, 0,8'h04,1,0), 101);
    applyStimulus(mk(1,1,0,K_NONE,3'b000,8'h00,8'h00,64'd0,3'b000, 0,8'h08,1,0), 102);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pc_gen.md
# pc_gen

Parametrised program-counter generator for the fetch stage of the RISC-V core. Holds the architectural fetch PC and advances it by 4 through a ripple-carry adder. It resolves conditional branches (all six RV32I/RV64I compare modes) and JAL/JALR redirects arriving from EX. A redirect that arrives while fetch is stalled is buffered until fetch can accept it.

## Interface
Parameters:
- ADDR_W, 8, PC / instruction-address width
- IMM_W, 64, width of the immediate from immgen
- RESET_PC, 0, PC value loaded on reset
- TRAP_PC, 4, PC loaded on a misaligned redirect target

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  synchronous, active-low reset
- if_ready  in  1  instruction memory accepts a fetch this cycle
- stall  in  1  hazard unit holds fetch
- ex_valid  in  1  EX stage holds a valid control-transfer instruction
- ex_op  in  3  branch funct3 (BEQ/BNE/BLT/BGE/BLTU/BGEU), ignored for jumps
- ex_branch / ex_jal / ex_jalr  in  1 each  instruction class, one-hot or all zero
- ex_pc  in  ADDR_W  PC of the EX instruction
- ex_rs1  in  ADDR_W  rs1 value (JALR base)
- ex_imm  in  IMM_W  immediate from immgen
- flag_zero, flag_lt, flag_ltu  in  1 each  ALU compare flags for EX
- pc  out  ADDR_W  current fetch address
- pc_valid  out  1  pc is a legal fetch request
- pc_plus4  out  ADDR_W  pc + 4, for link-register writeback
- flush  out  1  kill IF/ID, combinational
- misalign_err  out  1  one-cycle pulse on a misaligned redirect

## Operation
- take = ex_valid & (ex_jal | ex_jalr | (ex_branch & cond)). cond by ex_op:
  - BEQ: zero
  - BNE: !zero
  - BLT: lt
  - BGE: !lt
  - BLTU: ltu
  - BGEU: !ltu
  - Reserved ex_op codes 010 and 011 give cond = 0.
- Target address:
  - Branch / JAL: ex_pc + (ex_imm[ADDR_W-2:0] << 1).
  - JALR: (ex_rs1 + ex_imm[ADDR_W-1:0]) with bit 0 cleared.
  - All sums are modulo 2^ADDR_W; wrap-around is silent.
- Misaligned: take with target[1:0] != 0 → redirect goes to TRAP_PC instead; misalign_err = 1 on the next cycle.
- advance = if_ready & !stall.
- Per-cycle next PC, in priority order:
  1. !rst_n → RESET_PC, and the pending buffer is cleared.
  2. advance & take → target.
  3. advance & pend_v → pend_addr, and pend_v is cleared.
  4. advance → pc + 4.
  5. Otherwise pc holds.
- Buffering: take & !advance → pend_addr ← target (or TRAP_PC), pend_v ← 1. A new take overwrites an existing pending entry, so the youngest redirect wins.
- flush = take, asserted in the same cycle as take, whether or not advance is high.

## Timing
- Reset values: pc = RESET_PC, pc_valid = 0, misalign_err = 0, pending buffer empty.
- pc_valid rises on the first clock after rst_n goes high and stays 1.
- Redirect latency:
  - take in cycle N with advance → pc = target in cycle N+1.
  - take while stalled → pc = target in the first cycle after advance returns.
- pc_plus4 is combinational from pc.
- Reset asserted mid-redirect drops the pending redirect.

## Structure
- Shared package pc_pkg:
  - funct3 localparams BR_BEQ = 3'b000, BR_BNE = 3'b001, BR_BLT = 3'b100, BR_BGE = 3'b101, BR_BLTU = 3'b110, BR_BGEU = 3'b111.
  - Default RESET_PC and TRAP_PC.
- Sub-module pc_rca: ADDR_W-bit ripple-carry adder built from the existing full-adder cell.
  - Three instances: pc+4, branch/JAL target, JALR target.
  - Carry-out is unused.
- Top level contains only the condition decode, next-PC mux, PC register, and pending-redirect register.

## Test plan
- Reset release: rst_n 0→1 with if_ready = 1 and no stall → pc sequence 0x00, 0x04, 0x08; pc_valid 0 then 1.
- BNE taken: ex_pc = 0x10, ex_imm = 6, flag_zero = 0 → flush = 1 that cycle; next pc = 0x1C.
- Branch not taken and wrap-around (ADDR_W = 8):
  - BGE with flag_lt = 1 → pc increments by 4, flush = 0.
  - pc 0xFC → next pc 0x00.
- JALR: ex_rs1 = 0x21, ex_imm = 0x04 → target 0x24 (bit 0 cleared).
- JALR misaligned: ex_rs1 = 0x22, ex_imm = 0 → pc = TRAP_PC (0x04) next cycle; misalign_err pulses once.
- Stalled redirect:
  - JAL to 0x40 while stall = 1 for 3 cycles → pc holds; pc = 0x40 on the first cycle after stall drops.
  - Second take to 0x80 during the stall → pc = 0x80 instead of 0x40.
  - Reset during the stall → pc = RESET_PC and the pending redirect is lost.
